// File: rtl/bit_counter_pkg.sv
// Shared types and helpers for the streaming bit counter.
package bit_counter_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   typedef enum logic [1:0] {ONES, ZEROS, LEGACY, LZ} mode_t;

   // popcnt works on a fixed-width view; callers zero-extend narrower chunks.
   localparam int POP_MAX = 64;
   localparam int POP_W   = 7;

   function automatic logic [POP_W-1:0] popcnt(input logic [POP_MAX-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int b = 0; b < POP_MAX; b++) begin
         n = n + POP_W'(v[b]);
      end
      return n;
   endfunction

endpackage

// File: rtl/bit_chunk_count.sv
// Combinational per-chunk contribution for every counting mode.
module bit_chunk_count
   import bit_counter_pkg::*;
#(
   parameter int  STEP = 1,
   localparam int SW   = $clog2(STEP + 1)
) (
   input  logic [STEP-1:0] chunk,
   input  mode_t           mode,
   input  logic            legacy_msb,
   input  logic            mask,
   output logic [SW-1:0]   inc,
   output logic            lz_reset,
   output logic [SW-1:0]   lz_value
);

   logic [STEP-1:0] chunk_m;
   logic [SW-1:0]   ones;
   logic [SW-1:0]   valid_bits;
   logic [SW-1:0]   zeros;

   always_comb begin
      chunk_m = chunk;
      if (mask) begin
         chunk_m[STEP-1] = 1'b0;
      end
   end

   // A masked bit is neither a one nor a zero.
   assign ones       = SW'(popcnt(POP_MAX'(chunk_m)));
   assign valid_bits = mask ? SW'(STEP - 1) : SW'(STEP);
   assign zeros      = valid_bits - ones;

   // Ascending scan: the last hit is the highest set bit.
   always_comb begin
      lz_value = '0;
      for (int b = 0; b < STEP; b++) begin
         if (chunk[b]) begin
            lz_value = SW'(STEP - 1 - b);
         end
      end
   end

   assign lz_reset = (mode == LZ) && (|chunk);

   always_comb begin
      inc = '0;
      case (mode)
         ONES:    inc = ones;
         ZEROS:   inc = zeros;
         LEGACY:  inc = legacy_msb ? ones : zeros;
         LZ:      inc = (|chunk) ? '0 : SW'(STEP);
         default: inc = '0;
      endcase
   end

endmodule

// File: rtl/bit_counter_stream.sv
// Multi-mode serial bit counter: word in over Valid/Ready, STEP bits scanned per cycle, count out over OutValid/OutReady.
module bit_counter_stream
   import bit_counter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Valid,
   output logic             Ready,
   input  logic [WIDTH-1:0] DataIn,
   input  logic [1:0]       Mode,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [CW-1:0]    DataOut
);

   localparam int N  = WIDTH / STEP;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = $clog2(STEP + 1);

   generate
      if (WIDTH < 2 || (WIDTH % STEP) != 0 || STEP > POP_MAX) begin : g_bad_params
         $error("bit_counter_stream: WIDTH must be >= 2 and STEP must divide WIDTH");
      end
   endgenerate

   state_t           state_reg, state_next;
   mode_t            mode_reg;
   logic [WIDTH-1:0] word_reg;
   logic [IW-1:0]    idx_reg;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic [CW-1:0]    out_reg;

   logic [STEP-1:0]  chunks [N];
   logic [STEP-1:0]  chunk;
   logic             last_chunk;
   logic [SW-1:0]    inc;
   logic             lz_reset;
   logic [SW-1:0]    lz_value;

   for (genvar gi = 0; gi < N; gi++) begin : g_chunks
      assign chunks[gi] = word_reg[gi*STEP +: STEP];
   end

   assign chunk      = chunks[idx_reg];
   assign last_chunk = (idx_reg == IW'(N - 1));

   bit_chunk_count #(.STEP(STEP)) u_chunk (
      .chunk      (chunk),
      .mode       (mode_reg),
      .legacy_msb (word_reg[WIDTH-1]),
      .mask       ((mode_reg == LEGACY) && last_chunk),
      .inc        (inc),
      .lz_reset   (lz_reset),
      .lz_value   (lz_value)
   );

   // A set bit in LZ mode restarts the count from that chunk's own leading zeros.
   assign count_next = lz_reset ? CW'(lz_value) : count_reg + CW'(inc);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (Valid)      state_next = SCAN;
         SCAN:    if (last_chunk) state_next = DONE;
         DONE:    if (OutReady)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         mode_reg  <= ONES;
         word_reg  <= '0;
         idx_reg   <= '0;
         count_reg <= '0;
         out_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (Valid) begin
                  word_reg  <= DataIn;
                  mode_reg  <= mode_t'(Mode);
                  idx_reg   <= '0;
                  count_reg <= '0;
               end
            end
            SCAN: begin
               count_reg <= count_next;
               idx_reg   <= idx_reg + IW'(1);
               if (last_chunk) begin
                  out_reg <= count_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign Ready    = (state_reg == IDLE);
   assign OutValid = (state_reg == DONE);
   assign DataOut  = out_reg;

endmodule
